// File: rtl/exu_inst_queue.sv
// ---------------------------------------------------------------------------
// exu_inst_queue
//
// Instruction queue between the fetch unit (IFU) and the EXU decoder.
// Holds fetched {pc, inst} pairs in program order in a circular buffer and
// presents the oldest entry to decode. Both sides use valid/ready handshakes.
// A flush discards every entry for branch/exception redirects.
//
// Every output is driven from state: ifu_ready, dec_valid and count are flops,
// and dec_pc/dec_inst are read from the storage array at rd_ptr. There is no
// combinational path from ifu_* to dec_*, and none from dec_ready to ifu_ready.
// There is no bypass, so an entry reaches decode at the earliest one cycle
// after it is pushed.
//
// Parameters
//   DEPTH  entry count; must be a power of two and at least 2
//   PC_W   program counter width
//
// Ports
//   clk        in   clock; all state updates on posedge
//   rst        in   synchronous active-high reset; highest priority
//   flush      in   drop all entries at the next edge
//   ifu_valid  in   fetch offers {ifu_pc, ifu_inst}
//   ifu_ready  out  queue can accept an entry this cycle (not full)
//   ifu_pc     in   pc of the offered instruction
//   ifu_inst   in   offered instruction word
//   dec_valid  out  head entry is valid (not empty)
//   dec_ready  in   decoder consumes the head this cycle
//   dec_pc     out  pc of the head entry
//   dec_inst   out  instruction word of the head entry
//   count      out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module exu_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     ifu_valid,
  output logic                     ifu_ready,
  input  logic [PC_W-1:0]          ifu_pc,
  input  logic [31:0]              ifu_inst,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [PC_W-1:0]          dec_pc,
  output logic [31:0]              dec_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  // The extra MSB on each pointer is the wrap bit. It tells full apart from
  // empty when the index bits are equal.
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             drop;

  // A push depends only on the registered ifu_ready. A pop in the same cycle
  // does not free a slot for a push when the queue is full.
  assign push = ifu_valid && ifu_ready;
  assign pop  = dec_valid && dec_ready;
  assign drop = rst || flush;

  // NOTE: every variable written in always_comb gets a default first, so no
  // latch is inferred for the cases the case statement does not list.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointer, occupancy and handshake flags. Reset and flush act the same way:
  // both discard all entries, and both override any push or pop in that cycle.
  // ifu_ready and dec_valid are registered copies of the next occupancy, so
  // they change only at a clock edge.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (drop) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ifu_ready <= 1'b1;
      dec_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      ifu_ready <= (count_nxt != FULL_CNT);
      dec_valid <= (count_nxt != '0);
    end
  end

  // NOTE: the storage array has no reset. The pointers alone decide which
  // entries are live, so stale data is never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !drop) begin
      mem[wr_ptr[IDX_W-1:0]] <= '{pc: ifu_pc, inst: ifu_inst};
    end
  end

  // The head is a read of registered storage. It holds steady while the
  // decoder stalls, because rd_ptr and the head slot do not change then.
  assign head     = mem[rd_ptr[IDX_W-1:0]];
  assign dec_pc   = head.pc;
  assign dec_inst = head.inst;

endmodule

// File: tb/tb_exu_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_exu_inst_queue
//
// Directed testbench for exu_inst_queue with DEPTH=4 and PC_W=32.
// Most scenarios are held in a table of {inputs, expected state after the
// edge} records, which a loop applies and compares. A hand-written sequence
// streams pushes and pops at count=2 across several pointer wraps.
// ---------------------------------------------------------------------------
module tb_exu_inst_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ifu_valid;
  logic              ifu_ready;
  logic [PC_W-1:0]   ifu_pc;
  logic [31:0]       ifu_inst;
  logic              dec_valid;
  logic              dec_ready;
  logic [PC_W-1:0]   dec_pc;
  logic [31:0]       dec_inst;
  logic [2:0]        count;

  exu_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ifu_valid (ifu_valid),
    .ifu_ready (ifu_ready),
    .ifu_pc    (ifu_pc),
    .ifu_inst  (ifu_inst),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_pc    (dec_pc),
    .dec_inst  (dec_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // The expected fields give the state just after the edge on which the
  // inputs were applied.
  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        dr;
    logic [2:0]  cnt;
    logic        dv;
    logic        ir;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [31:0] pc, input logic dr,
                              input logic [2:0] cnt, input logic dv,
                              input logic ir, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst_of(pc);
    v.dr = dr; v.cnt = cnt; v.dv = dv; v.ir = ir; v.epc = epc;
    v.einst = inst_of(epc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic dr);
    rst = r; flush = f; ifu_valid = iv; ifu_pc = pc; ifu_inst = inst;
    dec_ready = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ifu_valid = 1'b0; ifu_pc = '0; ifu_inst = '0;
    dec_ready = 1'b0;

    // 1: reset, then a single push reaches decode one cycle later
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 3'd0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 3'd1, 1, 1, 32'h100));
    vecs[1].inst  = 32'h0000_0013;
    vecs[1].einst = 32'h0000_0013;
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd0, 0, 1, 32'h0));
    // 2: fill while decode stalls; a 5th offer is refused, the head holds
    vecs.push_back(mk(0, 0, 1, 32'h0,   0, 3'd1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h4,   0, 3'd2, 1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h8,   0, 3'd3, 1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'hC,   0, 3'd4, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h10,  0, 3'd4, 1, 0, 32'h0));
    // 3: full with offer and pop -> pop only; 0x10 goes in next; drain order
    vecs.push_back(mk(0, 0, 1, 32'h10,  1, 3'd3, 1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 1, 32'h10,  0, 3'd4, 1, 0, 32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd3, 1, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd2, 1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd1, 1, 1, 32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd0, 0, 1, 32'h0));
    // 5: flush at count=3 with push and pop in the same cycle
    vecs.push_back(mk(0, 0, 1, 32'h20,  0, 3'd1, 1, 1, 32'h20));
    vecs.push_back(mk(0, 0, 1, 32'h24,  0, 3'd2, 1, 1, 32'h20));
    vecs.push_back(mk(0, 0, 1, 32'h28,  0, 3'd3, 1, 1, 32'h20));
    vecs.push_back(mk(0, 1, 1, 32'h2C,  1, 3'd0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h200, 0, 3'd1, 1, 1, 32'h200));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd0, 0, 1, 32'h0));
    // 6: reset at count=4 together with flush, push and pop
    vecs.push_back(mk(0, 0, 1, 32'h300, 0, 3'd1, 1, 1, 32'h300));
    vecs.push_back(mk(0, 0, 1, 32'h304, 0, 3'd2, 1, 1, 32'h300));
    vecs.push_back(mk(0, 0, 1, 32'h308, 0, 3'd3, 1, 1, 32'h300));
    vecs.push_back(mk(0, 0, 1, 32'h30C, 0, 3'd4, 1, 0, 32'h300));
    vecs.push_back(mk(1, 1, 1, 32'h310, 1, 3'd0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h400, 0, 3'd1, 1, 1, 32'h400));
    vecs.push_back(mk(0, 0, 1, 32'h404, 1, 3'd1, 1, 1, 32'h404));
    vecs.push_back(mk(0, 0, 1, 32'h408, 0, 3'd2, 1, 1, 32'h404));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd1, 1, 1, 32'h408));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd0, 0, 1, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc,
            vecs[i].inst, vecs[i].dr);
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d dec_valid", i), 32'(dec_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d ifu_ready", i), 32'(ifu_ready), 32'(vecs[i].ir));
      if (vecs[i].dv) begin
        check($sformatf("v%0d dec_pc", i), dec_pc, vecs[i].epc);
        check($sformatf("v%0d dec_inst", i), dec_inst, vecs[i].einst);
      end
    end

    // 4: stream at count=2 for 20 instructions across several pointer wraps
    drive(0, 1, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 32'h0, inst_of(32'h0), 0);
    drive(0, 0, 1, 32'h4, inst_of(32'h4), 0);
    check("wrap prefill count", 32'(count), 32'd2);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 32'(4 * (k + 2)), inst_of(32'(4 * (k + 2))), 1);
      check($sformatf("wrap%0d count", k), 32'(count), 32'd2);
      check($sformatf("wrap%0d dec_pc", k), dec_pc, 32'(4 * (k + 1)));
      check($sformatf("wrap%0d dec_inst", k), dec_inst,
            inst_of(32'(4 * (k + 1))));
    end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    check("wrap drain1 dec_pc", dec_pc, 32'(4 * 21));
    check("wrap drain1 count", 32'(count), 32'd1);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    check("wrap drain2 count", 32'(count), 32'd0);
    check("wrap drain2 dec_valid", 32'(dec_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
